ex_result_buffer: RTL and testbench
===================================

EX_RESULT_BUFFER -- requirements
Module: ex_result_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of ALU result carried (matches bitwise logic unit output).
REQ-002 SHALL have parameter DEST_W, default 4, width of destination register index.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream result (from logic/ALU units) present this cycle.
REQ-006 in_ready  output  1  buffer can accept a word this cycle.
REQ-007 in_result  input  DATA_W  ALU/logic result.
REQ-008 in_dest  input  DEST_W  destination register index.
REQ-009 in_wr_en  input  1  result must be written back.
REQ-010 out_valid  output  1  buffered word available to writeback.
REQ-011 out_ready  input  1  writeback consumes word this cycle.
REQ-012 out_result  output  DATA_W  head-entry result.
REQ-013 out_dest  output  DEST_W  head-entry destination.
REQ-014 out_wr_en  output  1  head-entry write enable.
REQ-015 out_zero  output  1  head-entry result equals zero.
REQ-016 flush  input  1  synchronous discard of all buffered entries (branch mispredict).
REQ-017 occupancy  output  2  number of valid entries, 0..2.

Function
REQ-018 Buffer SHALL be a 2-entry FIFO (skid buffer); entries hold {result, dest, wr_en, zero}.
REQ-019 Transfer in SHALL occur on a clk edge when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-020 in_ready SHALL be a registered signal, 1 when occupancy < 2, and SHALL NOT depend combinationally on out_ready.
REQ-021 out_valid SHALL equal (occupancy != 0); out_* SHALL always reflect the head entry, held stable while out_valid && !out_ready.
REQ-022 zero flag SHALL be computed from in_result at capture (all DATA_W bits zero) and stored, not recomputed at output.
REQ-023 Latency SHALL be 1 cycle: a word accepted at edge N is visible on out_* after edge N when buffer was empty.
REQ-024 Ordering SHALL be strict FIFO; no word dropped or duplicated.
REQ-025 Occupancy states: EMPTY(0), ONE(1), FULL(2); push-only increments, pop-only decrements, simultaneous push and pop holds count.
REQ-026 Simultaneous push and pop when ONE: head replaced by incoming word, occupancy stays 1.
REQ-027 When FULL, in_ready=0; in_valid ignored; simultaneous pop makes in_ready=1 next cycle.
REQ-028 Pop when EMPTY SHALL be impossible (out_valid=0); out_ready ignored.
REQ-029 flush SHALL have priority over push and pop: next state EMPTY, in_ready=1, any same-cycle input word discarded.
REQ-030 When out_valid=0, out_result, out_dest, out_wr_en, out_zero SHALL be driven 0.
REQ-031 Read/write pointers SHALL be 1 bit each and wrap 1->0.

Reset
REQ-032 Assertion of rst_n=0 SHALL immediately clear occupancy to 0, pointers to 0, out_valid=0, all out_* data=0, in_ready=0.
REQ-033 in_ready SHALL go to 1 on the first clk edge after rst_n deasserts; reset mid-transfer SHALL discard all entries.
REQ-034 Entry storage SHALL be cleared by reset, no X on outputs.

Structure
REQ-035 Shared package SHALL hold DATA_W/DEST_W defaults and the entry field layout (result, dest, wr_en, zero) reused by writeback stage.
REQ-036 Storage SHALL be one sub-module, ex_entry_reg (single-entry register with load enable and async active-low clear), instantiated twice.
REQ-037 Control (pointers, occupancy, in_ready) SHALL reside in ex_result_buffer top level.

Verification
REQ-038 Reset then push 0x0000_00F0 dest 3 wr_en 1, out_ready=1 -> next cycle out_valid=1, out_result=0x0000_00F0, out_dest=3, out_zero=0.
REQ-039 out_ready=0, push 0xA, 0xB, attempt 0xC -> occupancy=2, in_ready=0, 0xC not accepted; then out_ready=1 -> 0xA, 0xB in order.
REQ-040 Push 0x0000_0000 -> out_zero=1; push 0xFFFF_FFFF -> out_zero=0.
REQ-041 Occupancy 1, simultaneous push 0x5 and pop -> old head delivered, occupancy 1, head=0x5.
REQ-042 Occupancy 2, flush with in_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=1, pushed word absent.
REQ-043 rst_n asserted asynchronously mid-cycle with occupancy 2 -> out_valid and occupancy 0 before next clk edge.

Source files
------------

// File: rtl/ex_result_buffer_pkg.sv
// Shared definitions for the EX result buffer and the writeback stage:
// default widths, occupancy encoding and the entry field layout.
package ex_result_buffer_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEST_W_DEF = 4;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Entry layout, MSB first: result, dest, wr_en, zero
  typedef struct packed {
    logic [DATA_W_DEF-1:0] result;
    logic [DEST_W_DEF-1:0] dest;
    logic                  wr_en;
    logic                  zero;
  } ex_entry_t;

  function automatic int entry_w(input int data_w, input int dest_w);
    return data_w + dest_w + 2;
  endfunction

endpackage

// File: rtl/ex_entry_reg.sv
// Single buffer entry: a register with load enable and async active-low clear.
module ex_entry_reg #(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) data_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/ex_result_buffer.sv
// Two-entry skid buffer between the ALU/logic units and writeback.
// in_ready is registered so it never depends combinationally on out_ready.
module ex_result_buffer
  import ex_result_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEST_W = DEST_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_wr_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_wr_en,
  output logic              out_zero,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  localparam int ENTRY_W = entry_w(DATA_W, DEST_W);

  occ_e               occ_q, occ_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               in_ready_q, in_ready_d;
  logic               push, pop;
  logic               load0, load1;
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] entry0, entry1;
  logic [ENTRY_W-1:0] head, head_vis;

  assign in_entry = {in_result, in_dest, in_wr_en, ~|in_result};

  // Flush overrides both handshakes so a same-cycle word is dropped.
  always_comb begin
    push       = in_valid && in_ready_q && !flush;
    pop        = (occ_q != OCC_EMPTY) && out_ready && !flush;
    occ_d      = occ_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    in_ready_d = in_ready_q;
    if (flush) begin
      occ_d      = OCC_EMPTY;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      in_ready_d = 1'b1;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   occ_d = (occ_q == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
        2'b01:   occ_d = (occ_q == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
        default: occ_d = occ_q;
      endcase
      in_ready_d = (occ_d != OCC_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= OCC_EMPTY;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign load0 = push && !wr_ptr_q;
  assign load1 = push &&  wr_ptr_q;

  ex_entry_reg #(.W(ENTRY_W)) u_entry0 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load0),
    .d     (in_entry),
    .q     (entry0)
  );

  ex_entry_reg #(.W(ENTRY_W)) u_entry1 (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load1),
    .d     (in_entry),
    .q     (entry1)
  );

  // Data outputs read as zero whenever nothing is buffered.
  always_comb begin
    head     = rd_ptr_q ? entry1 : entry0;
    head_vis = (occ_q != OCC_EMPTY) ? head : '0;
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (occ_q != OCC_EMPTY);
  assign occupancy  = occ_q;
  assign out_result = head_vis[ENTRY_W-1 -: DATA_W];
  assign out_dest   = head_vis[DEST_W+1 -: DEST_W];
  assign out_wr_en  = head_vis[1];
  assign out_zero   = head_vis[0];

endmodule

// File: tb/tb_ex_result_buffer.sv
// Directed self-checking bench for ex_result_buffer: reset, FIFO order,
// backpressure, zero flag, simultaneous push/pop, flush and async reset.
module tb_ex_result_buffer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [3:0]  in_dest;
  logic        in_wr_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_dest;
  logic        out_wr_en;
  logic        out_zero;
  logic        flush;
  logic [1:0]  occupancy;

  int assertCount = 0;
  int failCount   = 0;

  ex_result_buffer #(.DATA_W(32), .DEST_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_dest    (in_dest),
    .in_wr_en   (in_wr_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_dest   (out_dest),
    .out_wr_en  (out_wr_en),
    .out_zero   (out_zero),
    .flush      (flush),
    .occupancy  (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic [1:0] occ,
                            input logic vld, input logic rdy);
    checkOutput({tag, ".occupancy"}, 64'(occupancy), 64'(occ));
    checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(vld));
    checkOutput({tag, ".in_ready"},  64'(in_ready),  64'(rdy));
  endtask

  task automatic checkHead(input string tag, input logic [31:0] res,
                           input logic [3:0] dst, input logic we, input logic zr);
    checkOutput({tag, ".out_result"}, 64'(out_result), 64'(res));
    checkOutput({tag, ".out_dest"},   64'(out_dest),   64'(dst));
    checkOutput({tag, ".out_wr_en"},  64'(out_wr_en),  64'(we));
    checkOutput({tag, ".out_zero"},   64'(out_zero),   64'(zr));
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] r, input logic [3:0] d,
                               input logic we, input logic ordy, input logic fl);
    in_valid  = v;
    in_result = r;
    in_dest   = d;
    in_wr_en  = we;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_result = '0;
    in_dest   = '0;
    in_wr_en  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkState("reset", 2'd0, 1'b0, 1'b0);
    checkHead("reset", 32'h0, 4'h0, 1'b0, 1'b0);
    #10 rst_n = 1'b1;
    checkOutput("pre_edge.in_ready", 64'(in_ready), 64'd0);

    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    checkState("after_reset", 2'd0, 1'b0, 1'b1);

    // Single word, one-cycle latency
    applyStimulus(1'b1, 32'h0000_00F0, 4'd3, 1'b1, 1'b1, 1'b0);
    checkState("first_push", 2'd1, 1'b1, 1'b1);
    checkHead("first_push", 32'h0000_00F0, 4'd3, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    checkState("drain1", 2'd0, 1'b0, 1'b1);
    checkHead("drain1", 32'h0, 4'h0, 1'b0, 1'b0);

    // Fill under backpressure, third word rejected
    applyStimulus(1'b1, 32'hA, 4'd1, 1'b1, 1'b0, 1'b0);
    checkState("push_a", 2'd1, 1'b1, 1'b1);
    checkHead("push_a", 32'hA, 4'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hB, 4'd2, 1'b0, 1'b0, 1'b0);
    checkState("push_b", 2'd2, 1'b1, 1'b0);
    checkHead("push_b", 32'hA, 4'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hC, 4'd9, 1'b1, 1'b0, 1'b0);
    checkState("push_c", 2'd2, 1'b1, 1'b0);
    checkHead("push_c", 32'hA, 4'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    checkState("pop_a", 2'd1, 1'b1, 1'b1);
    checkHead("pop_a", 32'hB, 4'd2, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    checkState("pop_b", 2'd0, 1'b0, 1'b1);

    // Zero flag captured at entry
    applyStimulus(1'b1, 32'h0, 4'd5, 1'b1, 1'b0, 1'b0);
    checkState("push_zero", 2'd1, 1'b1, 1'b1);
    checkHead("push_zero", 32'h0, 4'd5, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 4'd6, 1'b1, 1'b1, 1'b0);
    checkState("push_ones", 2'd1, 1'b1, 1'b1);
    checkHead("push_ones", 32'hFFFF_FFFF, 4'd6, 1'b1, 1'b0);

    // Simultaneous push and pop at occupancy one replaces the head
    checkOutput("pushpop.old_head", 64'(out_result), 64'(32'hFFFF_FFFF));
    applyStimulus(1'b1, 32'h5, 4'd7, 1'b0, 1'b1, 1'b0);
    checkState("pushpop", 2'd1, 1'b1, 1'b1);
    checkHead("pushpop", 32'h5, 4'd7, 1'b0, 1'b0);

    // Flush while full drops everything including the same-cycle word
    applyStimulus(1'b1, 32'h11, 4'd1, 1'b1, 1'b0, 1'b0);
    checkState("fill_flush", 2'd2, 1'b1, 1'b0);
    checkHead("fill_flush", 32'h5, 4'd7, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h22, 4'd2, 1'b1, 1'b0, 1'b1);
    checkState("flush", 2'd0, 1'b0, 1'b1);
    checkHead("flush", 32'h0, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    checkState("post_flush", 2'd0, 1'b0, 1'b1);

    // Buffer reusable after flush
    applyStimulus(1'b1, 32'h33, 4'd3, 1'b1, 1'b0, 1'b0);
    checkHead("refill_33", 32'h33, 4'd3, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h44, 4'd4, 1'b1, 1'b0, 1'b0);
    checkState("refill_44", 2'd2, 1'b1, 1'b0);
    checkHead("refill_44", 32'h33, 4'd3, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with two entries held
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checkState("async_reset", 2'd0, 1'b0, 1'b0);
    checkHead("async_reset", 32'h0, 4'h0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    checkState("after_async", 2'd0, 1'b0, 1'b1);
    checkHead("after_async", 32'h0, 4'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
